// File: rtl/rv32_fetch_queue.sv
// rv32_fetch_queue: prefetch FIFO between instruction memory and decode.
// Show-ahead head outputs; a redirect flushes the queue and reloads the fetch PC.
module rv32_fetch_queue #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000,
    parameter int          LOG2_DEPTH   = 2,
    parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [31:0]           iaddress,
    output logic                  iread,
    input  logic [31:0]           ireaddata,
    input  logic                  iwaitrequest,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    output logic [31:0]           instr,
    output logic [31:0]           instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [LOG2_DEPTH:0]   level
);
    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FULL = (LOG2_DEPTH+1)'(DEPTH);
    logic [31:0]           fpc_q, fpc_d;
    logic [LOG2_DEPTH:0]   level_q, level_d;
    logic [LOG2_DEPTH-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [31:0]           pc_mem [DEPTH];
    logic [31:0]           data_mem [DEPTH];
    logic                  push, pop, empty;
    always_comb begin
        iread   = !reset && level_q != FULL;
        push    = iread && !iwaitrequest && !redirect;
        empty   = reset || level_q == '0;
        pop     = !empty && instr_ready && !redirect;
        fpc_d   = redirect ? {redirect_pc[31:2], 2'b00} : push ? fpc_q + 32'd4 : fpc_q;
        level_d = redirect ? '0 : level_q + (LOG2_DEPTH+1)'(push) - (LOG2_DEPTH+1)'(pop);
        wr_d    = redirect ? '0 : wr_q + LOG2_DEPTH'(push);
        rd_d    = redirect ? '0 : rd_q + LOG2_DEPTH'(pop);
    end
    assign iaddress    = fpc_q;
    assign level       = level_q;
    assign instr_valid = !empty;
    assign instr       = empty ? NOP_INSTR : data_mem[rd_q];
    assign instr_pc    = empty ? fpc_q : pc_mem[rd_q];
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q   <= RESET_VECTOR;
            level_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            fpc_q   <= fpc_d;
            level_q <= level_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end
    // storage is never read while empty, so it carries no reset
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_q]   <= fpc_q;
            data_mem[wr_q] <= ireaddata;
        end
    end
endmodule
